// File: rtl/truth_table_sweep_pkg.sv
// Shared types and constants for the truth-table sweep exerciser.
// Holds the FSM state enum, sweep geometry, settle limits and diff helpers.
package truth_table_sweep_pkg;

    localparam int MINTERMS   = 8;
    localparam int IDX_W      = 3;
    localparam int CNT_W      = 4;
    localparam int SETTLE_MIN = 1;
    localparam int SETTLE_MAX = 15;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MINTERMS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    function automatic logic [3:0] ones8(input logic [MINTERMS-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < MINTERMS; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // Lowest set bit index; 0 when no bit is set.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [MINTERMS-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = MINTERMS - 1; i >= 0; i--) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/truth_table_sweep_settle_timer.sv
// Loadable down-counter timing how long each minterm is held before sampling.
// Ports: clk, rst (async high), i_load/i_value (load), i_dec (count down), o_zero (count is 0).
module truth_table_sweep_settle_timer
    import truth_table_sweep_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_value,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/truth_table_sweep.sv
// Sweeps minterms 000..111 into a 3-input function, samples f_in per minterm after
// SETTLE cycles, and checks the captured 8-bit truth table against 'expected'.
// Ports: clk, rst (async high), start, expected[7:0], f_in -> a/b/c_out, busy,
// done (pulse), table_out[7:0], pass. Optional macro TRUTH_TABLE_MISMATCH_EN adds
// first_fail[2:0] and fail_count[3:0].
module truth_table_sweep
    import truth_table_sweep_pkg::*;
#(
    parameter int SETTLE = 1
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [MINTERMS-1:0] expected,
    input  logic                f_in,
    output logic                a_out,
    output logic                b_out,
    output logic                c_out,
    output logic                busy,
    output logic                done,
    output logic [MINTERMS-1:0] table_out,
    output logic                pass
`ifdef TRUTH_TABLE_MISMATCH_EN
    ,
    output logic [IDX_W-1:0]    first_fail,
    output logic [3:0]          fail_count
`endif
);

    if (SETTLE < SETTLE_MIN || SETTLE > SETTLE_MAX) begin : g_bad_settle
        $error("SETTLE out of range 1..15");
    end

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    w_idx_next;
    logic [2:0]          r_abc;
    logic [MINTERMS-1:0] r_table;
    logic [MINTERMS-1:0] w_table_next;
    logic                r_pass;
    logic                w_load;
    logic                w_dec;
    logic                w_zero;
    logic                w_start_ok;
    logic                w_match;
    logic                w_drive;

    truth_table_sweep_settle_timer u_settle_timer (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_value (LOAD_VAL),
        .i_dec   (w_dec),
        .o_zero  (w_zero)
    );

    assign w_start_ok = (r_state == ST_IDLE) && start;
    assign w_match    = (r_table == expected);

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_table_next = r_table;
        w_load       = 1'b0;
        w_dec        = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_SETTLE;
                    w_idx_next   = '0;
                    w_table_next = '0;
                    w_load       = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (w_zero) begin
                    w_state_next = ST_SAMPLE;
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_SAMPLE: begin
                w_table_next[r_idx] = f_in;
                if (r_idx == IDX_LAST) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_idx_next   = r_idx + 1'b1;
                    w_load       = 1'b1;
                    w_state_next = ST_SETTLE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Drive the minterm only while the next state is part of the sweep,
    // so a/b/c are already 0 in the DONE cycle.
    assign w_drive = (w_state_next == ST_SETTLE) || (w_state_next == ST_SAMPLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_abc   <= '0;
            r_table <= '0;
            r_pass  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_table <= w_table_next;
            r_abc   <= w_drive ? w_idx_next : 3'b000;
            if (w_start_ok) begin
                r_pass <= 1'b0;
            end else if (r_state == ST_DONE) begin
                r_pass <= w_match;
            end
        end
    end

    assign {a_out, b_out, c_out} = r_abc;
    assign busy      = (r_state == ST_SETTLE) || (r_state == ST_SAMPLE);
    assign done      = (r_state == ST_DONE);
    assign table_out = r_table;
    // In DONE the verdict is presented combinationally so it is valid with
    // the done pulse; it is then held in r_pass until the next start.
    assign pass      = (r_state == ST_DONE) ? w_match : r_pass;

`ifdef TRUTH_TABLE_MISMATCH_EN
    logic [IDX_W-1:0]    r_first_fail;
    logic [3:0]          r_fail_count;
    logic [MINTERMS-1:0] w_diff;

    assign w_diff = r_table ^ expected;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_first_fail <= '0;
            r_fail_count <= '0;
        end else if (w_start_ok) begin
            r_first_fail <= '0;
            r_fail_count <= '0;
        end else if (r_state == ST_DONE) begin
            r_first_fail <= lowest_set(w_diff);
            r_fail_count <= ones8(w_diff);
        end
    end

    assign first_fail = (r_state == ST_DONE) ? lowest_set(w_diff) : r_first_fail;
    assign fail_count = (r_state == ST_DONE) ? ones8(w_diff) : r_fail_count;
`endif

endmodule

// File: tb/tb_truth_table_sweep.sv
// Scoreboard bench for truth_table_sweep: two instances (SETTLE=1 and SETTLE=4)
// driven by table-lookup function models, checked against a cycle-arithmetic model.
module tb_truth_table_sweep;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_s [2];
    logic [7:0] exp_s   [2];
    logic       f_s     [2];
    logic       a_s     [2];
    logic       b_s     [2];
    logic       c_s     [2];
    logic       busy_s  [2];
    logic       done_s  [2];
    logic [7:0] tab_s   [2];
    logic       pass_s  [2];
`ifdef TRUTH_TABLE_MISMATCH_EN
    logic [2:0] ff_s    [2];
    logic [3:0] fc_s    [2];
`endif

    logic [7:0] tt [2];
    logic [2:0] dl1 = 3'b000;
    logic [2:0] dl2 = 3'b000;
    logic [2:0] dl3 = 3'b000;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    truth_table_sweep #(.SETTLE(1)) u_dut0 (
        .clk(clk), .rst(rst), .start(start_s[0]), .expected(exp_s[0]),
        .f_in(f_s[0]), .a_out(a_s[0]), .b_out(b_s[0]), .c_out(c_s[0]),
        .busy(busy_s[0]), .done(done_s[0]), .table_out(tab_s[0]),
        .pass(pass_s[0])
`ifdef TRUTH_TABLE_MISMATCH_EN
        , .first_fail(ff_s[0]), .fail_count(fc_s[0])
`endif
    );

    truth_table_sweep #(.SETTLE(4)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_s[1]), .expected(exp_s[1]),
        .f_in(f_s[1]), .a_out(a_s[1]), .b_out(b_s[1]), .c_out(c_s[1]),
        .busy(busy_s[1]), .done(done_s[1]), .table_out(tab_s[1]),
        .pass(pass_s[1])
`ifdef TRUTH_TABLE_MISMATCH_EN
        , .first_fail(ff_s[1]), .fail_count(fc_s[1])
`endif
    );

    // Function under test: instant lookup for dut0, 3-cycle delayed for dut1.
    assign f_s[0] = tt[0][{a_s[0], b_s[0], c_s[0]}];
    assign f_s[1] = tt[1][dl3];
    always @(posedge clk) begin
        dl1 <= {a_s[1], b_s[1], c_s[1]};
        dl2 <= dl1;
        dl3 <= dl2;
    end

    typedef struct {
        int         d;
        int         t;
        logic [7:0] tab;
        logic       ok;
    } exp_t;

    exp_t       sbq [$];
    int         acc       [2] = '{-1, -1};
    int         idle_from [2] = '{0, 0};
    logic [7:0] cur_tt    [2] = '{8'h00, 8'h00};
    logic [7:0] last_tab  [2] = '{8'h00, 8'h00};
    logic       last_pass [2] = '{1'b0, 1'b0};

    task automatic chk(input string nm, input int d,
                       input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h",
                     nm, d, cyc, act, want);
        end
    endtask

    function automatic int sv(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    function automatic int find_q(input int d);
        for (int i = 0; i < sbq.size(); i++) begin
            if (sbq[i].d == d) return i;
        end
        return -1;
    endfunction

    function automatic logic [7:0] majority_tt();
        logic [7:0] r;
        logic [2:0] m3;
        for (int m = 0; m < 8; m++) begin
            m3   = 3'(m);
            r[m] = ($countones(m3) >= 2);
        end
        return r;
    endfunction

    // Monitor / scoreboard: sweep timing is derived from the acceptance cycle.
    always @(negedge clk) begin
        int         s;
        int         span;
        int         o;
        int         k;
        logic [7:0] mask;
        logic [2:0] lo;
        for (int d = 0; d < 2; d++) begin
            s    = sv(d);
            span = 8 * (s + 1);
            if (rst) begin
                chk("rst_outputs", d,
                    {20'd0, tab_s[d], a_s[d], b_s[d], c_s[d], busy_s[d], done_s[d], pass_s[d]}, 0);
                for (int i = sbq.size() - 1; i >= 0; i--) begin
                    if (sbq[i].d == d) sbq.delete(i);
                end
                acc[d]       = -1;
                idle_from[d] = 0;
                last_tab[d]  = 8'h00;
                last_pass[d] = 1'b0;
            end else begin
                o = (acc[d] >= 0) ? (cyc - acc[d]) : -1;
                if (o >= 1 && o <= span) begin
                    for (int m = 0; m < 8; m++) mask[m] = ((m + 1) * (s + 1) < o);
                    chk("busy_hi", d, busy_s[d], 1);
                    chk("done_lo", d, done_s[d], 0);
                    chk("abc_step", d, {a_s[d], b_s[d], c_s[d]}, (o - 1) / (s + 1));
                    chk("table_partial", d, tab_s[d], cur_tt[d] & mask);
                    chk("pass_busy", d, pass_s[d], 0);
                end else if (o == span + 1) begin
                    chk("busy_done", d, busy_s[d], 0);
                    chk("abc_done", d, {a_s[d], b_s[d], c_s[d]}, 0);
                end else begin
                    chk("idle_out", d,
                        {a_s[d], b_s[d], c_s[d], busy_s[d], done_s[d]}, 0);
                    chk("table_hold", d, tab_s[d], last_tab[d]);
                    chk("pass_hold", d, pass_s[d], last_pass[d]);
                end
                k = find_q(d);
                if (done_s[d]) begin
                    if (k < 0) begin
                        chk("done_unexpected", d, 1, 0);
                    end else begin
                        chk("done_cycle", d, cyc, sbq[k].t);
                        chk("table_final", d, tab_s[d], sbq[k].tab);
                        chk("pass_final", d, pass_s[d], sbq[k].ok);
`ifdef TRUTH_TABLE_MISMATCH_EN
                        lo = 3'd0;
                        for (int m = 7; m >= 0; m--) begin
                            if (sbq[k].tab[m] != exp_s[d][m]) lo = 3'(m);
                        end
                        chk("first_fail", d, ff_s[d], lo);
                        chk("fail_count", d, fc_s[d], $countones(sbq[k].tab ^ exp_s[d]));
`else
                        lo = 3'd0;
`endif
                        last_tab[d]  = sbq[k].tab;
                        last_pass[d] = sbq[k].ok;
                        sbq.delete(k);
                    end
                end else if (k >= 0 && cyc > sbq[k].t) begin
                    chk("done_missing", d, 0, 1);
                    sbq.delete(k);
                end
                if (start_s[d] && cyc >= idle_from[d]) begin
                    acc[d]       = cyc;
                    cur_tt[d]    = tt[d];
                    idle_from[d] = cyc + span + 2;
                    last_tab[d]  = 8'h00;
                    last_pass[d] = 1'b0;
                    sbq.push_back('{d: d, t: cyc + span + 1,
                                    tab: tt[d], ok: (tt[d] == exp_s[d])});
                end
            end
        end
    end

    task automatic pulse(input int d);
        start_s[d] = 1'b1;
        @(posedge clk); #1;
        start_s[d] = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sbq.size() > 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (n >= 500) chk("wait_timeout", 0, 1, 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        start_s[0] = 1'b0;
        start_s[1] = 1'b0;
        exp_s[0]   = 8'h00;
        exp_s[1]   = 8'h00;
        tt[0]      = 8'h00;
        tt[1]      = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Majority, matching expectation.
        tt[0] = majority_tt();
        exp_s[0] = 8'hE8;
        pulse(0);
        wait_idle();

        // Majority, one-bit wrong expectation.
        exp_s[0] = 8'hE9;
        pulse(0);
        wait_idle();

        // SETTLE=4 with delayed function output.
        tt[1] = majority_tt();
        exp_s[1] = 8'hE8;
        pulse(1);
        wait_idle();

        // Re-pulse mid-sweep is ignored.
        exp_s[0] = 8'hE8;
        pulse(0);
        repeat (4) @(posedge clk);
        #1;
        pulse(0);
        wait_idle();

        // Reset mid-sweep aborts; a fresh sweep then completes.
        pulse(0);
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_async", d,
                {20'd0, tab_s[d], a_s[d], b_s[d], c_s[d], busy_s[d], done_s[d], pass_s[d]}, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        tt[0] = 8'h5A;
        exp_s[0] = 8'h5A;
        pulse(0);
        wait_idle();

        // Start held high: back-to-back sweeps.
        tt[0] = majority_tt();
        exp_s[0] = 8'hE8;
        start_s[0] = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        start_s[0] = 1'b0;
        wait_idle();

        // Random functions and expectations on both instances.
        for (int it = 0; it < 12; it++) begin
            for (int d = 0; d < 2; d++) begin
                tt[d] = 8'($urandom);
                if ($urandom_range(0, 1) == 1) exp_s[d] = tt[d];
                else exp_s[d] = tt[d] ^ (8'h01 << $urandom_range(0, 7));
            end
            start_s[0] = 1'b1;
            start_s[1] = 1'b1;
            @(posedge clk); #1;
            start_s[0] = 1'b0;
            start_s[1] = 1'b0;
            wait_idle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
